keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  4x4 matrix-keypad front end: drives rows, samples columns, debounces whole scan frames.
//  Emits the 16-bit one-hot key code plus valid/press strobes for the onehot-to-binary encoder stage.
//  Bit index = row*4 + col; board wiring maps bits to digits. All outputs registered.
// PARAMETERS
//  SCAN_DIV      1000  clocks each row is driven before its columns are sampled (>=2)
//  DEBOUNCE_CNT  4     additional identical frames required after the first (>=1)
//  REPEAT_FRAMES 64    frames between auto-repeat pulses (used only with KEYPAD_AUTOREPEAT_EN)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  col_in     in   4   column sense, active-low (pulled up; 0 = key closed on driven row)
//  row_out    out  4   row drive, active-low, exactly one bit low at any time
//  onehot     out  16  debounced one-hot key code; 0 when no key or multiple keys
//  key_valid  out  1   1 while onehot holds exactly one set bit
//  key_pulse  out  1   one-clock strobe on each new accepted press (and repeats if enabled)
// BEHAVIOUR
//  Reset (rst=1 at posedge): row_out=4'b1110, onehot=0, key_valid=0, key_pulse=0,
//   all counters/frame registers 0, FSM=IDLE.
//  Scan: tick_cnt counts 0..SCAN_DIV-1. When tick_cnt==SCAN_DIV-1:
//   raw[row*4+c] <= ~col_in[c]; row advances 0->1->2->3->0 (row_out rotates left, wraps).
//   Column sampling happens only on that cycle. The frame ends when row 3 is sampled
//   (frame = 4*SCAN_DIV clocks).
//  Frame debounce, evaluated on the frame-end cycle:
//   new frame == prev frame -> stable_cnt++ (saturates at DEBOUNCE_CNT); else stable_cnt=0.
//   prev <= new frame. When stable_cnt reaches DEBOUNCE_CNT, debounced <= frame.
//   An accepted change therefore needs DEBOUNCE_CNT+1 consecutive identical frames.
//  Outputs update 1 clk after the debounced update:
//   popcount(debounced)==1 -> onehot=debounced, key_valid=1.
//   popcount 0 or >=2 -> onehot=0, key_valid=0. Multi-key input is rejected, not prioritised.
//  FSM (frame-end transitions only):
//   IDLE -> PRESSED: single key accepted; key_pulse=1 for that one clk.
//   PRESSED -> PRESSED: same key still accepted; no pulse.
//   PRESSED -> IDLE: release or multi-key accepted.
//   PRESSED -> PRESSED: different single key accepted directly (roll-over); fresh key_pulse,
//    onehot switches to the new key.
//  Bounce of less than DEBOUNCE_CNT+1 frames never changes any output.
//  rst mid-frame: abandons the partial frame and restarts at row 0. A held key must
//   re-debounce from scratch and then yields one key_pulse.
// CONFIGURATION
//  KEYPAD_AUTOREPEAT_EN defined:
//   - in PRESSED with the same key, repeat_cnt counts frames;
//   - each REPEAT_FRAMES frames emits an extra one-clk key_pulse;
//   - repeat_cnt clears on any state or key change.
//  Not defined: exactly one key_pulse per accepted press; repeat_cnt not instantiated.
// STRUCTURE
//  Package keypad_pkg: KP_ROWS=4, KP_COLS=4, KP_KEYS=16, FSM state typedef
//   {KP_IDLE, KP_PRESSED}, function kp_bit(row,col)=row*4+col.
//  One sub-module: frame_debouncer (WIDTH, DEBOUNCE_CNT). Inputs frame/frame_stb;
//   outputs debounced/deb_stb. The top keeps scan counter, FSM, popcount check, repeat logic.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CNT=2, REPEAT_FRAMES=3; frame = 16 clks)
//  - Reset with col_in=4'hF -> row_out=4'b1110; onehot=0, key_valid=0; row_out
//    rotates every 4 clks and wraps.
//  - Hold row1/col2 closed (col_in[2]=0 only while row_out[1]=0) -> onehot=16'h0040,
//    key_valid=1 after 3 frames+1 clk; exactly one key_pulse.
//  - Key closes 1 frame, opens 1, closes 1 (bounce) -> onehot stays 0, no key_pulse;
//    steady close afterwards -> accepted normally.
//  - Two keys held (bits 3 and 5) -> onehot=0, key_valid=0, no pulse;
//    release bit 5 -> onehot=16'h0008 with one pulse.
//  - Held key, rst asserted mid-frame for 1 clk -> outputs 0 next clk;
//    re-accepted after 3 frames with one pulse.
//  - KEYPAD_AUTOREPEAT_EN: hold key 12 frames -> first pulse, then a pulse every 3 frames;
//    release -> pulses stop.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;
  localparam int unsigned KP_KEYS = KP_ROWS * KP_COLS;

  typedef enum logic [0:0] {
    KP_IDLE,
    KP_PRESSED
  } kp_state_e;

  function automatic int unsigned kp_bit(input int unsigned row, input int unsigned col);
    return row * KP_COLS + col;
  endfunction

  // True when exactly one bit of the frame is set.
  function automatic logic kp_is_single(input logic [KP_KEYS-1:0] v);
    return (v != '0) && ((v & (v - KP_KEYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/frame_debouncer.sv
// Whole-frame debouncer: a frame is accepted after DEBOUNCE_CNT+1 identical frames in a row.
module frame_debouncer #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] frame,
  input  logic             frame_stb,
  output logic [WIDTH-1:0] debounced,
  output logic             deb_stb
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] debounced_q, debounced_d;
  logic [CntW-1:0]  stable_q, stable_d;
  logic             deb_stb_q, deb_stb_d;

  always_comb begin
    prev_d      = prev_q;
    stable_d    = stable_q;
    debounced_d = debounced_q;
    deb_stb_d   = 1'b0;
    if (frame_stb) begin
      prev_d = frame;
      if (frame == prev_q) begin
        stable_d = (stable_q == CntMax) ? stable_q : stable_q + CntW'(1);
      end else begin
        stable_d = '0;
      end
      // Strobe on every stable frame so the consumer can count held frames.
      if (stable_d == CntMax) begin
        debounced_d = frame;
        deb_stb_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      stable_q    <= '0;
      debounced_q <= '0;
      deb_stb_q   <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      debounced_q <= debounced_d;
      deb_stb_q   <= deb_stb_d;
    end
  end

  assign debounced = debounced_q;
  assign deb_stb   = deb_stb_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row drive, column sampling, frame debounce, press FSM.
// Define KEYPAD_AUTOREPEAT_EN to emit repeat pulses every REPEAT_FRAMES held frames.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned DEBOUNCE_CNT  = 4,
  parameter int unsigned REPEAT_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KP_COLS-1:0]  col_in,
  output logic [KP_ROWS-1:0]  row_out,
  output logic [KP_KEYS-1:0]  onehot,
  output logic                key_valid,
  output logic                key_pulse
);

  localparam int unsigned TickW = $clog2(SCAN_DIV);

  logic [TickW-1:0]   tick_q, tick_d;
  logic [1:0]         row_q, row_d;
  logic [KP_ROWS-1:0] row_out_q, row_out_d;
  logic [KP_KEYS-1:0] raw_q, raw_d;
  logic               sample;
  logic               frame_stb;

  logic [KP_KEYS-1:0] debounced;
  logic               deb_stb;
  logic               single;

  kp_state_e          state_q, state_d;
  logic [KP_KEYS-1:0] onehot_q, onehot_d;
  logic               key_valid_q, key_valid_d;
  logic               key_pulse_q, key_pulse_d;

  assign sample    = (tick_q == TickW'(SCAN_DIV - 1));
  assign frame_stb = sample && (row_q == 2'd3);

  always_comb begin
    tick_d    = sample ? '0 : tick_q + TickW'(1);
    row_d     = sample ? row_q + 2'd1 : row_q;
    row_out_d = sample ? {row_out_q[KP_ROWS-2:0], row_out_q[KP_ROWS-1]} : row_out_q;
    raw_d     = raw_q;
    if (sample) begin
      for (int unsigned c = 0; c < KP_COLS; c++) begin
        raw_d[kp_bit(32'(row_q), c)] = ~col_in[c];
      end
    end
  end

  // raw_d already holds row 3 on the frame-end cycle, so the full frame is handed over.
  frame_debouncer #(
    .WIDTH       (KP_KEYS),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_frame_debouncer (
    .clk      (clk),
    .rst      (rst),
    .frame    (raw_d),
    .frame_stb(frame_stb),
    .debounced(debounced),
    .deb_stb  (deb_stb)
  );

  assign single = kp_is_single(debounced);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_FRAMES + 1);
  logic [RepW-1:0] repeat_q, repeat_d;
`endif

  always_comb begin
    state_d     = state_q;
    onehot_d    = single ? debounced : '0;
    key_valid_d = single;
    key_pulse_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    repeat_d    = repeat_q;
`endif
    if (deb_stb) begin
`ifdef KEYPAD_AUTOREPEAT_EN
      repeat_d = '0;
`endif
      unique case (state_q)
        KP_IDLE: begin
          if (single) begin
            state_d     = KP_PRESSED;
            key_pulse_d = 1'b1;
          end
        end
        KP_PRESSED: begin
          if (!single) begin
            state_d = KP_IDLE;
          end else if (debounced != onehot_q) begin
            key_pulse_d = 1'b1;
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (repeat_q == RepW'(REPEAT_FRAMES - 1)) begin
              key_pulse_d = 1'b1;
            end else begin
              repeat_d = repeat_q + RepW'(1);
            end
`endif
          end
        end
        default: state_d = KP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= '0;
      row_q       <= '0;
      row_out_q   <= 4'b1110;
      raw_q       <= '0;
      state_q     <= KP_IDLE;
      onehot_q    <= '0;
      key_valid_q <= 1'b0;
      key_pulse_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      repeat_q    <= '0;
`endif
    end else begin
      tick_q      <= tick_d;
      row_q       <= row_d;
      row_out_q   <= row_out_d;
      raw_q       <= raw_d;
      state_q     <= state_d;
      onehot_q    <= onehot_d;
      key_valid_q <= key_valid_d;
      key_pulse_q <= key_pulse_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      repeat_q    <= repeat_d;
`endif
    end
  end

  assign row_out   = row_out_q;
  assign onehot    = onehot_q;
  assign key_valid = key_valid_q;
  assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner: frame-level key model, pulse queue, random key patterns.
module tb_keypad_scanner;

  localparam int unsigned SD    = 4;
  localparam int unsigned DC    = 2;
  localparam int unsigned RF    = 3;
  localparam int unsigned FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_pulse;
  logic [15:0] pressed = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];

  // Frame-level reference state.
  logic [15:0] m_prev;
  int          m_run;
  logic [15:0] m_acc;
  logic [15:0] m_key;
  int          m_rep;
  logic [15:0] exp_oh;
  bit          chk_pending;

  always #5 clk = ~clk;

  // Ideal switch matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DC),
    .REPEAT_FRAMES(RF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .onehot   (onehot),
    .key_valid(key_valid),
    .key_pulse(key_pulse)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest expected press.
  always @(negedge clk) begin
    if (!rst && key_pulse) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got onehot %h expected no pulse at %0t", onehot, $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("pulse_key", onehot, e);
        chk("pulse_valid", 16'(key_valid), 16'd1);
      end
    end
  end

  function automatic void model_reset();
    m_prev = '0;
    m_run  = 1;   // reset contents act as one all-zero frame
    m_acc  = '0;
    m_key  = '0;
    m_rep  = 0;
    exp_oh = '0;
  endfunction

  function automatic void model_frame(input logic [15:0] f);
    if (f == m_prev) m_run++;
    else m_run = 1;
    m_prev = f;
    if (m_run >= DC + 1) begin
      m_acc = f;
      if ($countones(f) == 1) begin
        if (m_key != f) begin
          exp_q.push_back(f);
          m_key = f;
          m_rep = 0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          m_rep++;
          if (m_rep == RF) begin
            exp_q.push_back(f);
            m_rep = 0;
          end
`endif
        end
      end else begin
        m_key = '0;
        m_rep = 0;
      end
    end
    exp_oh = ($countones(m_acc) == 1) ? m_acc : '0;
  endfunction

  task automatic check_pending();
    if (chk_pending) begin
      chk("onehot", onehot, exp_oh);
      chk("key_valid", 16'(key_valid), 16'(exp_oh != '0));
    end
  endtask

  // Caller is #1 after the clock edge that ends the previous frame.
  task automatic run_frame(input logic [15:0] keys);
    pressed = keys;
    @(posedge clk); #1;
    check_pending();
    repeat (FRAME - 1) @(posedge clk);
    #1;
    model_frame(keys);
    chk_pending = 1'b1;
  endtask

  task automatic run_frames(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) run_frame(keys);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk_pending = 1'b0;
  endtask

  initial begin
    logic [3:0]  rot;
    logic [15:0] k;
    int          a;
    int          b;

    model_reset();
    chk_pending = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_row_out", 16'(row_out), 16'h000E);
    chk("reset_onehot", onehot, 16'h0000);
    chk("reset_valid", 16'(key_valid), 16'd0);
    chk("reset_pulse", 16'(key_pulse), 16'd0);

    rot = 4'b1110;
    for (int i = 1; i <= 8; i++) begin
      repeat (SD) @(posedge clk);
      #1;
      rot = {rot[2:0], rot[3]};
      chk("row_rotate", 16'(row_out), 16'(rot));
    end

    do_reset();

    // Row 1 / column 2 held.
    run_frames(16'h0040, 4);
    run_frames(16'h0000, 4);

    // Bounce, then a steady press.
    run_frame(16'h0200);
    run_frame(16'h0000);
    run_frame(16'h0200);
    run_frames(16'h0000, 3);
    run_frames(16'h0200, 4);
    run_frames(16'h0000, 4);

    // Two keys rejected, then one released.
    run_frames(16'h0028, 4);
    run_frames(16'h0008, 4);
    run_frames(16'h0000, 4);

    // Reset in the middle of a frame while a key is held.
    run_frames(16'h1000, 4);
    pressed = 16'h1000;
    @(posedge clk); #1;
    check_pending();
    repeat (6) @(posedge clk);
    #1;
    do_reset();
    chk("midrst_onehot", onehot, 16'h0000);
    chk("midrst_valid", 16'(key_valid), 16'd0);
    chk("midrst_pulse", 16'(key_pulse), 16'd0);
    chk("midrst_row_out", 16'(row_out), 16'h000E);
    run_frames(16'h1000, 4);
    run_frames(16'h0000, 4);

    // Long hold (repeats when auto-repeat is built in), then release.
    run_frames(16'h0001, 12);
    run_frames(16'h0000, 4);

    // Randomized key patterns of random duration.
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 3))
        0: k = '0;
        2: begin
          a = int'($urandom_range(0, 15));
          b = (a + 1 + int'($urandom_range(0, 14))) % 16;
          k = (16'd1 << a) | (16'd1 << b);
        end
        default: k = 16'd1 << $urandom_range(0, 15);
      endcase
      run_frames(k, int'($urandom_range(1, 5)));
    end

    run_frames(16'h0000, 4);
    chk("pulses_outstanding", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
